// File: rtl/prog_inst_mem.sv
// Programmable instruction memory for the fetch stage.
// Registered fetch port, valid/ready load port, self-clearing array.
module prog_inst_mem #(
  parameter int XLEN        = 32,
  parameter int ILEN        = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            fetch_req,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid,
  output logic [ILEN-1:0] fetch_inst,
  output logic            fetch_fault,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [XLEN-1:0] load_addr,
  input  logic [ILEN-1:0] load_data,
  input  logic            clear_start,
  output logic            busy,
  output logic            load_err,
  output logic [31:0]     load_count
);

  localparam int WB    = ILEN / 8;
  localparam int WORDS = DEPTH_BYTES / WB;
  localparam int AL    = $clog2(WB);
  localparam int IW    = $clog2(WORDS);

  localparam logic [XLEN-1:0] ALIGN_MASK =
    XLEN'(WB - 1);
  localparam logic [XLEN-1:0] DEPTH_LIM =
    XLEN'(DEPTH_BYTES);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(WORDS - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic          ok;
    logic [IW-1:0] idx;
  } dec_t;

  // Alignment, range and word index of a byte address.
  function automatic dec_t decode(
    input logic [XLEN-1:0] a
  );
    logic [XLEN-1:0] off;
    logic [XLEN-1:0] sh;
    dec_t d;
    off   = a - BASE_ADDR;
    sh    = off >> AL;
    d.ok  = ((a & ALIGN_MASK) == '0) &&
            (off < DEPTH_LIM);
    d.idx = sh[IW-1:0];
    return d;
  endfunction

  state_t        state;
  logic [IW-1:0] clr_idx;

  logic [ILEN-1:0] mem [WORDS];

  dec_t ld_dec;
  dec_t fe_dec;

  logic ld_fire;
  logic ld_wr;
  logic fe_acc;
  logic fe_hit;

  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [ILEN-1:0] wr_data;

  assign busy       = (state == S_CLEAR);
  assign load_ready = (state == S_IDLE);

  assign ld_dec  = decode(load_addr);
  assign fe_dec  = decode(fetch_pc);

  assign ld_fire = load_valid && load_ready;
  assign ld_wr   = ld_fire && ld_dec.ok;
  assign fe_acc  = fetch_req && !busy;

  // Same-edge load to the fetched word wins.
  assign fe_hit  = ld_wr &&
                   (ld_dec.idx == fe_dec.idx);

  // Single write port: the fill owns it in CLEAR.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    unique case (1'b1)
      busy: begin
        wr_en  = 1'b1;
        wr_idx = clr_idx;
      end
      ld_wr: begin
        wr_en   = 1'b1;
        wr_idx  = ld_dec.idx;
        wr_data = load_data;
      end
      default: ;
    endcase
  end

  // Storage is never reset; the fill zeroes it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Fill sequencer plus load bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_CLEAR;
      clr_idx    <= '0;
      load_err   <= 1'b0;
      load_count <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + IW'(1);
          if (clr_idx == LAST_IDX) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (clear_start) begin
            state      <= S_CLEAR;
            clr_idx    <= '0;
            load_err   <= 1'b0;
            load_count <= '0;
          end else if (ld_fire) begin
            if (!ld_dec.ok) begin
              load_err <= 1'b1;
            end else if (load_count != '1) begin
              load_count <= load_count + 32'd1;
            end
          end
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

  // Registered fetch response, one cycle latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_inst  <= '0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_valid <= fe_acc;
      fetch_fault <= 1'b0;
      if (fe_acc) begin
        if (!fe_dec.ok) begin
          fetch_fault <= 1'b1;
          fetch_inst  <= '0;
        end else if (fe_hit) begin
          fetch_inst  <= load_data;
        end else begin
          fetch_inst  <= mem[fe_dec.idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_inst_mem.sv
// Randomized bench for prog_inst_mem against a
// behavioural array model.
module tb_prog_inst_mem;

  localparam int WORDS = 256;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        fetch_fault;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        clear_start = 1'b0;
  logic        busy;
  logic        load_err;
  logic [31:0] load_count;

  always #5 clock = ~clock;

  prog_inst_mem dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_fault (fetch_fault),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .clear_start (clear_start),
    .busy        (busy),
    .load_err    (load_err),
    .load_count  (load_count)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [WORDS];
  int          m_busy;
  logic        m_err;
  logic [31:0] m_cnt;
  logic        m_fv;
  logic        m_ff;
  logic [31:0] m_fi;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(
    input logic [31:0] a
  );
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  function automatic int widx(
    input logic [31:0] a
  );
    return int'(a / 4);
  endfunction

  task automatic m_zero();
    for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
  endtask

  task automatic chk_outs();
    chk("fetch_valid", 64'(fetch_valid), 64'(m_fv));
    chk("fetch_inst",  64'(fetch_inst),  64'(m_fi));
    chk("fetch_fault", 64'(fetch_fault), 64'(m_ff));
    chk("busy",        64'(busy),  64'(m_busy != 0));
    chk("load_ready",  64'(load_ready),
        64'(m_busy == 0));
    chk("load_err",    64'(load_err),    64'(m_err));
    chk("load_count",  64'(load_count),  64'(m_cnt));
  endtask

  // One clock: drive, advance model, check after edge.
  task automatic cyc(
    input bit          fr,
    input logic [31:0] fpc,
    input bit          lv,
    input logic [31:0] la,
    input logic [31:0] ld,
    input bit          cs
  );
    bit idle;
    fetch_req   = fr;
    fetch_pc    = fpc;
    load_valid  = lv;
    load_addr   = la;
    load_data   = ld;
    clear_start = cs;
    idle = (m_busy == 0);
    if (lv && idle) begin
      if (addr_ok(la)) begin
        m_mem[widx(la)] = ld;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
    m_fv = fr && idle;
    m_ff = 1'b0;
    if (m_fv) begin
      if (addr_ok(fpc)) begin
        m_fi = m_mem[widx(fpc)];
      end else begin
        m_ff = 1'b1;
        m_fi = '0;
      end
    end
    if (cs && idle) begin
      m_zero();
      m_err  = 1'b0;
      m_cnt  = '0;
      m_busy = WORDS;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    @(posedge clock);
    #1;
    chk_outs();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Async reset from a point away from the edge.
  task automatic do_reset(input int n);
    fetch_req   = 1'b0;
    load_valid  = 1'b0;
    clear_start = 1'b0;
    reset_n = 1'b0;
    m_busy = WORDS;
    m_err  = 1'b0;
    m_cnt  = '0;
    m_fv   = 1'b0;
    m_ff   = 1'b0;
    m_fi   = '0;
    m_zero();
    #1;
    chk_outs();
    repeat (n) @(posedge clock);
    #1;
    chk_outs();
    reset_n = 1'b1;
    #1;
    chk_outs();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 1) == 0)
      a = 32'($urandom_range(0, 15)) * 4;
    else
      a = 32'($urandom_range(0, WORDS + 7)) * 4;
    if ($urandom_range(0, 7) == 0)
      a = a + 32'($urandom_range(1, 3));
    if ($urandom_range(0, 31) == 0)
      a = $urandom;
    return a;
  endfunction

  initial begin
    m_zero();
    #1;
    do_reset(3);
    idle_n(WORDS);
    cyc(1'b1, 32'h0, 1'b0, '0, '0, 1'b0);

    cyc(1'b0, '0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    cyc(1'b0, '0, 1'b1, 32'h14, 32'h00112233, 1'b0);
    cyc(1'b1, 32'h10, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 32'h14, 1'b0, '0, '0, 1'b0);
    idle_n(1);

    cyc(1'b1, 32'h12, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 32'h400, 1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, 32'h401, 32'h5555, 1'b0);
    cyc(1'b1, 32'h20, 1'b1, 32'h20,
        32'hCAFEF00D, 1'b0);
    idle_n(1);

    cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 99; i++)
      cyc(1'b1, 32'h10, 1'b1, 32'h24, 32'h77, 1'b0);
    do_reset(3);
    for (int i = 0; i < WORDS + 2; i++)
      cyc(1'b1, 32'h10, 1'b0, '0, '0, 1'b0);

    cyc(1'b0, '0, 1'b1, 32'h30, 32'h1234, 1'b0);
    cyc(1'b1, 32'h30, 1'b1, 32'h34, 32'h9, 1'b1);
    for (int i = 0; i < WORDS; i++)
      cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 32'h30, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 32'h34, 1'b0, '0, '0, 1'b0);

    cyc(1'b0, '0, 1'b1, 32'h8, 32'hA5A5, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, '0, '0, 1'b0);
    do_reset(2);
    idle_n(WORDS);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 2) != 0),
          rand_addr(),
          ($urandom_range(0, 2) != 0),
          rand_addr(),
          $urandom,
          ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/prog_inst_mem.md
Name: prog_inst_mem

Overview:
Programmable, parametrised instruction memory for the core's fetch stage. Fetch is a registered port with one cycle of latency, plus alignment and range fault reporting. Programs are loaded through a valid/ready port. A built-in state machine zero-fills the whole array after reset and on request, so storage needs no reset of its own. It sits between the fetch stage and the test-bench/boot loader.

Parameters:
XLEN, 32, address width of fetch_pc and load_addr
ILEN, 32, instruction/word width in bits; multiple of 8, power of two
DEPTH_BYTES, 1024, storage size in bytes; power of two, multiple of ILEN/8
BASE_ADDR, 0, byte address mapped to array word 0; aligned to DEPTH_BYTES

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
fetch_req  input  1  fetch request for fetch_pc this cycle
fetch_pc  input  XLEN  byte address of instruction
fetch_valid  output  1  response valid (one cycle after accepted request)
fetch_inst  output  ILEN  fetched instruction, little-endian byte order
fetch_fault  output  1  with fetch_valid: request was misaligned or out of range
load_valid  input  1  load word offered
load_ready  output  1  load port can accept
load_addr  input  XLEN  byte address of load word
load_data  input  ILEN  load word, little-endian
clear_start  input  1  request full zero-fill
busy  output  1  zero-fill in progress
load_err  output  1  sticky: a dropped load was misaligned or out of range
load_count  output  32  accepted, in-range loads since last clear; saturates at 0xFFFFFFFF

Behaviour:
- Derived values: WB = ILEN/8; WORDS = DEPTH_BYTES/WB; AL = log2(WB).
- Address check for any addr:
  - aligned = addr[AL-1:0]==0.
  - in_range = (addr - BASE_ADDR) < DEPTH_BYTES, unsigned, XLEN-bit wrap.
  - Word index = (addr - BASE_ADDR) >> AL.
- Async reset, applied immediately on reset_n low:
  - Outputs: fetch_valid=0, fetch_inst=0, fetch_fault=0, load_err=0, load_count=0.
  - Internal: state=CLEAR, clr_idx=0.
  - busy=1 and load_ready=0 while reset_n is low.
  - The array itself is not reset.
- FSM, two states:
  - CLEAR: each cycle writes word clr_idx to 0 and increments clr_idx. After the write of index WORDS-1 the next state is IDLE, so busy is high for exactly WORDS cycles after reset release.
  - IDLE -> CLEAR when clear_start=1. On that edge clr_idx=0, load_err=0 and load_count=0.
  - clear_start in CLEAR is ignored; the fill does not restart.
- busy = (state==CLEAR). load_ready = (state==IDLE), combinational from state.
- Load port:
  - A transfer occurs when load_valid && load_ready at a rising edge.
  - Aligned and in range: word is written at that edge and load_count increments (saturating).
  - Otherwise: no write, load_err set to 1. load_err is sticky until clear or reset.
  - load_valid while not ready: nothing happens. The initiator holds load_addr/load_data until the transfer.
  - If clear_start and load_valid are both high in IDLE, the load transfers (writes) on that edge and CLEAR starts on the same edge. The fill then zeroes it, and load_count ends at 0.
- Fetch port:
  - Request accepted when fetch_req && !busy. No request while busy means no response; fetch_valid=0 next cycle.
  - The accepted request's response appears in the next cycle with fetch_valid=1, and fetch_valid is high for exactly one cycle.
  - Aligned and in range: fetch_fault=0, fetch_inst = stored word.
  - Otherwise: fetch_fault=1, fetch_inst=0.
  - Back-to-back requests give back-to-back responses, throughput one per cycle.
  - fetch_valid=0 cycles: fetch_fault=0; fetch_inst holds its last value.
- Same-edge load and fetch to the same word: write-first. The response carries the newly loaded load_data.
- Reset asserted mid-CLEAR or mid-load: the FSM restarts the fill from index 0 after release. Any in-flight fetch response is dropped (fetch_valid=0).

Test Plan:
- Reset release -> busy=1 for exactly 256 cycles (default params), load_ready=0 throughout. Then busy=0, and a fetch of 0x0 returns fetch_valid=1, fetch_inst=0x00000000, fetch_fault=0.
- Load 0xDEADBEEF @0x10 and 0x00112233 @0x14. Fetch 0x10, 0x14 on back-to-back cycles -> responses 0xDEADBEEF then 0x00112233 on consecutive cycles, load_count=2.
- Fetch 0x12 -> fetch_fault=1, inst=0. Fetch 0x400 -> fault=1. Load to 0x401 -> no write, load_err=1, load_count unchanged.
- Same-edge load 0xCAFEF00D @0x20 and fetch 0x20 -> response 0xCAFEF00D next cycle.
- After loads, pulse clear_start -> load_err=0, load_count=0, busy=1 for 256 cycles. Fetch during busy -> no fetch_valid. Afterwards fetch 0x10 -> 0x0.
- Assert reset_n low mid-clear at cycle 100 for 3 cycles -> outputs at reset values immediately. The fill restarts and busy lasts a full 256 cycles after release.
